// File: rtl/zone_led_sched_pkg.sv
// Shared constants and state encoding for the backlight zone scheduler.
package zone_led_sched_pkg;

   localparam int unsigned NUM_ZONES = 360;
   localparam int unsigned ZONE_GW   = 8;
   localparam int unsigned IDX_W     = $clog2(NUM_ZONES);

   typedef enum logic [1:0] {
      StIdle,
      StCapture,
      StSend,
      StDone
   } state_e;

endpackage

// File: rtl/zone_led_sched_duty_scale.sv
// Combinational gain scaling with a minimum-duty floor for one zone.
module zone_duty_scale #(
   parameter int unsigned GW = 8
) (
   input  logic [GW-1:0] gray,
   input  logic [GW-1:0] gain,
   input  logic [GW-1:0] floor_duty,
   output logic [GW-1:0] duty
);

   logic [2*GW-1:0] prod;
   logic [GW-1:0]   scaled;

   // gain is a fraction of 256, so the scale is a fixed 8-bit shift
   assign prod   = gray * gain;
   assign scaled = GW'(prod >> 8);
   assign duty   = (scaled < floor_duty) ? floor_duty : scaled;

endmodule

// File: rtl/zone_led_sched.sv
// Streams one captured frame of zone duties to an LED driver over valid/ready.
module zone_led_sched
   import zone_led_sched_pkg::*;
#(
   parameter int unsigned ZONES = NUM_ZONES,
   parameter int unsigned GW    = ZONE_GW
) (
   input  logic                i_pix_clk,
   input  logic                rst,
   input  logic                frame_done,
   input  logic [ZONES*GW-1:0] buf_360_flatted,
   input  logic [GW-1:0]       gain,
   input  logic [GW-1:0]       floor_duty,
   input  logic                clr_overrun,
   output logic                zone_valid,
   input  logic                zone_ready,
   output logic [IDX_W-1:0]    zone_idx,
   output logic [GW-1:0]       zone_duty,
   output logic                busy,
   output logic                frame_sent,
   output logic                overrun
);

   state_e           state;
   logic [GW-1:0]    shadow_buf [ZONES];
   logic [GW-1:0]    shadow_gain;
   logic [GW-1:0]    shadow_floor;
   logic [IDX_W-1:0] next_idx;
   logic [GW-1:0]    duty_next;
   logic             last_zone;

   assign last_zone = (zone_idx == IDX_W'(ZONES - 1));
   assign busy      = (state != StIdle);

   // Clamped to 0 outside SEND so the mux never addresses past the last zone
   assign next_idx  = (state == StSend && !last_zone) ? zone_idx + IDX_W'(1) : '0;

   zone_duty_scale #(
      .GW (GW)
   ) u_scale (
      .gray       (shadow_buf[next_idx]),
      .gain       (shadow_gain),
      .floor_duty (shadow_floor),
      .duty       (duty_next)
   );

   // Shadow copy has no reset: its contents only matter after a capture
   always_ff @(posedge i_pix_clk) begin
      if (state == StIdle && frame_done) begin
         for (int i = 0; i < int'(ZONES); i++) begin
            shadow_buf[i] <= buf_360_flatted[i*GW +: GW];
         end
         shadow_gain  <= gain;
         shadow_floor <= floor_duty;
      end
   end

   always_ff @(posedge i_pix_clk or posedge rst) begin
      if (rst) begin
         state      <= StIdle;
         zone_valid <= 1'b0;
         zone_idx   <= '0;
         zone_duty  <= '0;
         frame_sent <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         frame_sent <= 1'b0;
         if (frame_done && state != StIdle) begin
            overrun <= 1'b1;
         end else if (clr_overrun) begin
            overrun <= 1'b0;
         end
         unique case (state)
            StIdle: begin
               if (frame_done) begin
                  state <= StCapture;
               end
            end
            StCapture: begin
               zone_idx   <= '0;
               zone_duty  <= duty_next;
               zone_valid <= 1'b1;
               state      <= StSend;
            end
            StSend: begin
               if (zone_ready) begin
                  if (last_zone) begin
                     zone_valid <= 1'b0;
                     frame_sent <= 1'b1;
                     state      <= StDone;
                  end else begin
                     zone_idx  <= next_idx;
                     zone_duty <= duty_next;
                  end
               end
            end
            StDone: begin
               state <= StIdle;
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_zone_led_sched.sv
// Randomized frame streaming checked against an arithmetic model of the zone schedule.
module tb_zone_led_sched;

   localparam int ZONES  = 360;
   localparam int GW     = 8;
   localparam int BUDGET = 4000;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                frame_done = 1'b0;
   logic                clr_overrun = 1'b0;
   logic                zone_ready = 1'b0;
   logic [ZONES*GW-1:0] buf_in = '0;
   logic [GW-1:0]       gain = '0;
   logic [GW-1:0]       floor_duty = '0;
   logic                zone_valid;
   logic [8:0]          zone_idx;
   logic [GW-1:0]       zone_duty;
   logic                busy;
   logic                frame_sent;
   logic                overrun;

   int n_cmp = 0;
   int n_bad = 0;
   int mdl_gray [ZONES];
   int mdl_gain;
   int mdl_floor;
   bit ov_mdl = 1'b0;

   zone_led_sched #(
      .ZONES (ZONES),
      .GW    (GW)
   ) dut (
      .i_pix_clk       (clk),
      .rst             (rst),
      .frame_done      (frame_done),
      .buf_360_flatted (buf_in),
      .gain            (gain),
      .floor_duty      (floor_duty),
      .clr_overrun     (clr_overrun),
      .zone_valid      (zone_valid),
      .zone_ready      (zone_ready),
      .zone_idx        (zone_idx),
      .zone_duty       (zone_duty),
      .busy            (busy),
      .frame_sent      (frame_sent),
      .overrun         (overrun)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, got %0d compared expected completion",
               n_cmp);
      $fatal(1, "watchdog");
   end

   function automatic int exp_duty(int g, int gn, int fl);
      int d;
      d = (g * gn) / 256;
      return (d > fl) ? d : fl;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic fill_buf(int mode, int val);
      for (int i = 0; i < ZONES; i++) begin
         case (mode)
            0:       buf_in[i*GW +: GW] = GW'(i % 256);
            1:       buf_in[i*GW +: GW] = GW'($urandom);
            default: buf_in[i*GW +: GW] = GW'(val);
         endcase
      end
   endtask

   task automatic chk_idle_outputs(string tag);
      chk({tag, "_valid"}, 32'(zone_valid), 0);
      chk({tag, "_idx"},   32'(zone_idx),   0);
      chk({tag, "_duty"},  32'(zone_duty),  0);
      chk({tag, "_busy"},  32'(busy),       0);
      chk({tag, "_sent"},  32'(frame_sent), 0);
      chk({tag, "_ovr"},   32'(overrun),    0);
   endtask

   // Called at a negedge; returns at the negedge where zone_valid should first be high.
   task automatic start_frame();
      for (int i = 0; i < ZONES; i++) mdl_gray[i] = int'(buf_in[i*GW +: GW]);
      mdl_gain   = int'(gain);
      mdl_floor  = int'(floor_duty);
      frame_done = 1'b1;
      @(negedge clk);
      frame_done = 1'b0;
      chk("capture_valid", 32'(zone_valid), 0);
      chk("capture_busy",  32'(busy),       1);
      @(negedge clk);
   endtask

   task automatic clear_overrun();
      clr_overrun = 1'b1;
      @(negedge clk);
      clr_overrun = 1'b0;
      ov_mdl = 1'b0;
      chk("clr_overrun", 32'(overrun), 0);
   endtask

   // mode: 0 ready always, 1 ready 1-on/2-off, 2 random ready.
   task automatic consume(int mode, int pulse_at, int chg_at, int rst_at, bit clr_with_pulse,
                          bit done_pulse);
      int  k   = 0;
      int  cyc = 0;
      bit  rdy;
      while (k < ZONES && cyc < BUDGET) begin
         frame_done  = 1'b0;
         clr_overrun = 1'b0;
         chk("valid", 32'(zone_valid), 1);
         chk("idx",   32'(zone_idx),   32'(k));
         chk("duty",  32'(zone_duty),  32'(exp_duty(mdl_gray[k], mdl_gain, mdl_floor)));
         if (k == rst_at) begin
            rst        = 1'b1;
            zone_ready = 1'b0;
            #1;
            chk_idle_outputs("midframe_rst");
            @(negedge clk);
            rst    = 1'b0;
            ov_mdl = 1'b0;
            return;
         end
         if (k == chg_at) begin
            fill_buf(1, 0);
            gain       = GW'($urandom);
            floor_duty = GW'($urandom);
            chg_at     = -1;
         end
         if (k == pulse_at) begin
            frame_done  = 1'b1;
            clr_overrun = clr_with_pulse;
            ov_mdl      = 1'b1;
            pulse_at    = -1;
         end
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = (cyc % 3) == 0;
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         zone_ready = rdy;
         if (rdy) k++;
         @(negedge clk);
         cyc++;
      end
      frame_done  = 1'b0;
      clr_overrun = 1'b0;
      zone_ready  = 1'b0;
      if (cyc >= BUDGET) chk("frame_timeout", 32'(k), 32'(ZONES));
      chk("done_valid", 32'(zone_valid), 0);
      chk("done_sent",  32'(frame_sent), 1);
      chk("done_busy",  32'(busy),       1);
      if (done_pulse) begin
         frame_done = 1'b1;
         ov_mdl     = 1'b1;
      end
      @(negedge clk);
      frame_done = 1'b0;
      chk("after_sent", 32'(frame_sent), 0);
      chk("after_busy", 32'(busy),       0);
      chk("after_ovr",  32'(overrun),    32'(ov_mdl));
      if (done_pulse) begin
         @(negedge clk);
         chk("no_restart_busy",  32'(busy),       0);
         chk("no_restart_valid", 32'(zone_valid), 0);
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk_idle_outputs("reset");
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("post_reset_busy", 32'(busy), 0);

      // Ramp buffer at half gain, back-to-back
      fill_buf(0, 0);
      gain = 8'd128;
      floor_duty = 8'd0;
      start_frame();
      consume(0, -1, -1, -1, 1'b0, 1'b0);

      // Random data with 1-on/2-off ready
      fill_buf(1, 0);
      gain = GW'($urandom);
      floor_duty = GW'($urandom_range(0, 60));
      start_frame();
      consume(1, -1, -1, -1, 1'b0, 1'b0);

      // Floor dominates, then zero gain
      fill_buf(2, 10);
      gain = 8'd255;
      floor_duty = 8'd40;
      start_frame();
      consume(0, -1, -1, -1, 1'b0, 1'b0);
      fill_buf(1, 0);
      gain = 8'd0;
      floor_duty = GW'($urandom);
      start_frame();
      consume(2, -1, -1, -1, 1'b0, 1'b0);

      // Full-scale gray with full gain
      fill_buf(1, 0);
      for (int i = 0; i < 8; i++) buf_in[i*GW +: GW] = 8'd255;
      gain = 8'd255;
      floor_duty = 8'd0;
      start_frame();
      consume(2, -1, -1, -1, 1'b0, 1'b0);

      // Re-trigger mid-frame with new inputs: overrun, frame keeps captured data
      fill_buf(1, 0);
      gain = GW'($urandom);
      floor_duty = GW'($urandom_range(0, 30));
      start_frame();
      consume(0, 100, 100, -1, 1'b0, 1'b0);
      clear_overrun();

      // Inputs change after capture; overrun set wins over a same-edge clear
      fill_buf(1, 0);
      gain = GW'($urandom);
      floor_duty = 8'd0;
      start_frame();
      consume(2, 50, 5, -1, 1'b1, 1'b0);
      clear_overrun();

      // frame_done on the DONE->IDLE edge is an overrun, not a new frame
      fill_buf(1, 0);
      gain = GW'($urandom);
      start_frame();
      consume(0, -1, -1, -1, 1'b0, 1'b1);
      clear_overrun();

      // Reset mid-frame, then a fresh frame starts at zone 0
      fill_buf(1, 0);
      gain = GW'($urandom);
      floor_duty = GW'($urandom_range(0, 50));
      start_frame();
      consume(0, 150, -1, 200, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      chk("post_rst_idle_busy",  32'(busy),       0);
      chk("post_rst_idle_valid", 32'(zone_valid), 0);
      fill_buf(1, 0);
      gain = GW'($urandom);
      start_frame();
      consume(2, -1, -1, -1, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
